// File: rtl/dmem_line_fill_pkg.sv
// Shared line-fill configuration: line geometry, memory bus width and fill FSM encoding.
// The data cache pulls the same definitions so both sides agree on line layout.
package dmem_line_fill_pkg;

  localparam int DMEM_LINE    = 512;
  localparam int DMEM_BLK_LEN = 58;
  localparam int DMEM_BUS_W   = 64;
  localparam int DMEM_BEATS   = DMEM_LINE / DMEM_BUS_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BEAT = 2'd2,
    S_DONE = 2'd3
  } fill_state_e;

endpackage

// File: rtl/dmem_line_fill.sv
// Data-cache line-fill engine: one burst read per miss, beats assembled in ascending
// order into a full line, returned with a one-cycle b_dv_d pulse.
module dmem_line_fill
  import dmem_line_fill_pkg::*;
#(
  parameter int BLK_LEN = DMEM_BLK_LEN,
  parameter int LINE    = DMEM_LINE,
  parameter int BUS_W   = DMEM_BUS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_d,
  input  logic               b_rd_d,
  output logic [LINE-1:0]    b_rdata_d,
  output logic               b_dv_d,
  output logic [63:0]        m_addr,
  output logic [7:0]         m_len,
  output logic               m_req,
  input  logic               m_gnt,
  input  logic [BUS_W-1:0]   m_rdata,
  input  logic               m_rvalid,
  input  logic               m_rlast,
  output logic               busy,
  output logic               fill_err
);

  localparam int BEATS = LINE / BUS_W;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  fill_state_e        state;
  logic [BLK_LEN-1:0] addr_q;
  logic [CW-1:0]      beat_cnt;
  logic [LINE-1:0]    line_q;
  logic               last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign m_addr    = {addr_q, {(64-BLK_LEN){1'b0}}};
  assign m_len     = 8'(BEATS - 1);
  assign busy      = (state != S_IDLE);
  assign b_rdata_d = line_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      beat_cnt <= '0;
      line_q   <= '0;
      m_req    <= 1'b0;
      b_dv_d   <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      b_dv_d <= 1'b0;
      case (state)
        S_IDLE: if (b_rd_d) begin
          addr_q   <= b_addr_d;
          beat_cnt <= '0;
          m_req    <= 1'b1;
          state    <= S_REQ;
        end
        S_REQ: if (m_gnt) begin
          m_req <= 1'b0;
          state <= S_BEAT;
        end
        S_BEAT: if (m_rvalid) begin
          line_q[BUS_W*beat_cnt +: BUS_W] <= m_rdata;
          beat_cnt <= beat_cnt + CW'(1);
          // rlast is only cross-checked; completion is decided by the beat count
          if (m_rlast != last_beat) fill_err <= 1'b1;
          if (last_beat) begin
            b_dv_d <= 1'b1;
            state  <= S_DONE;
          end
        end
        // one dead cycle so the still-held request can't launch a duplicate fill
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_fill.sv
// Directed bench for dmem_line_fill: basic, stalled, mismatch, back-to-back and reset fills.
module tb_dmem_line_fill;
  import dmem_line_fill_pkg::*;

  localparam int BLK_LEN = DMEM_BLK_LEN;
  localparam int LINE    = DMEM_LINE;
  localparam int BUS_W   = DMEM_BUS_W;
  localparam int BEATS   = LINE / BUS_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [BLK_LEN-1:0] b_addr_d = '0;
  logic               b_rd_d = 1'b0;
  logic [LINE-1:0]    b_rdata_d;
  logic               b_dv_d;
  logic [63:0]        m_addr;
  logic [7:0]         m_len;
  logic               m_req;
  logic               m_gnt = 1'b0;
  logic [BUS_W-1:0]   m_rdata = '0;
  logic               m_rvalid = 1'b0;
  logic               m_rlast = 1'b0;
  logic               busy;
  logic               fill_err;

  dmem_line_fill dut (
    .clk(clk), .rst_n(rst_n), .b_addr_d(b_addr_d), .b_rd_d(b_rd_d),
    .b_rdata_d(b_rdata_d), .b_dv_d(b_dv_d), .m_addr(m_addr), .m_len(m_len),
    .m_req(m_req), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .busy(busy), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor, sampled on the falling edge
  int          dv_total = 0, dv_last = 0, req_total = 0, err_rise = -1;
  logic        err_prev = 1'b0;
  logic [63:0] req_addr = '0;
  always @(negedge clk) begin
    if (b_dv_d) begin dv_total <= dv_total + 1; dv_last <= cyc; end
    if (m_req) begin req_total <= req_total + 1; req_addr <= m_addr; end
    if (fill_err && !err_prev) err_rise <= cyc;
    err_prev <= fill_err;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [LINE-1:0] mk_line(input logic [63:0] base);
    logic [LINE-1:0] l;
    for (int i = 0; i < BEATS; i++) l[BUS_W*i +: BUS_W] = base + 64'(i);
    return l;
  endfunction

  // Cache + bus model for one fill; returns with b_rd_d dropped in the cycle after b_dv_d.
  task automatic run_fill(input logic [BLK_LEN-1:0] addr, input int gnt_dly, input int gap_at,
                          input int gap_len, input int rlast_at, input logic [63:0] base,
                          output int t0);
    int k;
    tick(); b_rd_d = 1'b1; b_addr_d = addr; t0 = cyc;
    tick(); b_addr_d = ~addr; m_rvalid = 1'b1; m_rdata = 64'hDEAD; m_rlast = 1'b1;
    for (int i = 0; i <= gnt_dly; i++) begin
      if (i > 0) tick();
      m_gnt = (i == gnt_dly);
    end
    for (int b = 0; b < BEATS; b++) begin
      tick(); m_gnt = 1'b0;
      m_rvalid = 1'b1; m_rdata = base + 64'(b); m_rlast = (b == rlast_at);
      if (b == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          tick(); m_rvalid = 1'b0; m_rdata = 64'hBAD0; m_rlast = 1'b1;
        end
    end
    tick(); m_rvalid = 1'b0; m_rlast = 1'b0;
    k = 0;
    while (!b_dv_d && k < 40) begin tick(); k++; end
    chk("dv_wait", b_dv_d, 1'b1);
    tick(); b_rd_d = 1'b0;
  endtask

  initial begin
    int t0, dv0, req0;
    // reset state
    repeat (3) tick();
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_b_dv_d", b_dv_d, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill_err", fill_err, 1'b0);
    chk("rst_rdata", b_rdata_d, '0);
    chk("rst_m_len", m_len, 8'd7);
    rst_n = 1'b1;
    tick();

    // basic fill, immediate grant
    dv0 = dv_total; req0 = req_total;
    run_fill(58'h1, 0, -1, 0, 7, 64'h0, t0);
    tick();
    chk("basic_dv_cyc", dv_last - t0, 10);
    chk("basic_dv_cnt", dv_total - dv0, 1);
    chk("basic_req_cycles", req_total - req0, 1);
    chk("basic_m_addr", req_addr, 64'h40);
    chk("basic_line", b_rdata_d, mk_line(64'h0));
    chk("basic_fill_err", fill_err, 1'b0);
    chk("basic_busy_after", busy, 1'b0);

    // stalled grant and a 2-cycle beat gap after beat 3
    dv0 = dv_total; req0 = req_total;
    run_fill(58'h2, 3, 3, 2, 7, 64'h100, t0);
    tick();
    chk("stall_dv_cyc", dv_last - t0, 15);
    chk("stall_dv_cnt", dv_total - dv0, 1);
    chk("stall_req_cycles", req_total - req0, 4);
    chk("stall_m_addr", req_addr, 64'h80);
    chk("stall_line", b_rdata_d, mk_line(64'h100));
    chk("stall_fill_err", fill_err, 1'b0);

    // early rlast on beat 5
    dv0 = dv_total;
    run_fill(58'h3, 0, -1, 0, 5, 64'h200, t0);
    chk("mis_err_rise", err_rise - t0, 8);
    chk("mis_dv_cyc", dv_last - t0, 10);
    chk("mis_line", b_rdata_d, mk_line(64'h200));
    chk("mis_line_hold", b_rdata_d, mk_line(64'h200));

    // back-to-back: new request two cycles after the pulse, max block address
    run_fill({BLK_LEN{1'b1}}, 0, -1, 0, 7, 64'h300, t0);
    tick();
    chk("b2b_dv_cyc", dv_last - t0, 10);
    chk("b2b_dv_cnt", dv_total - dv0, 2);
    chk("b2b_m_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFC0);
    chk("b2b_line", b_rdata_d, mk_line(64'h300));
    chk("b2b_err_sticky", fill_err, 1'b1);
    repeat (3) tick();
    chk("b2b_no_dup", dv_total - dv0, 2);

    // reset after beat 4
    dv0 = dv_total;
    tick(); b_rd_d = 1'b1; b_addr_d = 58'h5;
    tick(); m_gnt = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h400 + 64'(b); m_rlast = 1'b0;
    end
    chk("rstm_busy_pre", busy, 1'b1);
    tick(); rst_n = 1'b0; b_rd_d = 1'b0; m_rdata = 64'h405;
    tick(); rst_n = 1'b1; m_rdata = 64'h406;
    chk("rstm_m_req", m_req, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_rdata", b_rdata_d, '0);
    chk("rstm_fill_err", fill_err, 1'b0);
    tick(); m_rdata = 64'h407; m_rlast = 1'b1;
    tick(); m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (5) tick();
    chk("rstm_no_dv", dv_total - dv0, 0);
    chk("rstm_idle_busy", busy, 1'b0);
    chk("rstm_idle_rdata", b_rdata_d, '0);

    // rlast never asserted: error flagged after the last beat
    run_fill(58'h6, 0, -1, 0, 8, 64'h500, t0);
    chk("nolast_err_rise", err_rise - t0, 10);
    chk("nolast_dv_cyc", dv_last - t0, 10);
    chk("nolast_line", b_rdata_d, mk_line(64'h500));
    chk("nolast_m_addr", req_addr, 64'h180);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
